// File: rtl/tx_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tx_block_scheduler
// Purpose  : Per-cycle TX sequencer in front of data_controller. Chooses,
//            cycle by cycle, whether the lanes carry IDLE blocks, clock-
//            compensation (CC) ordered sets or AXI user data. Sends the
//            post-init warm-up idles and inserts periodic CC bursts that
//            may preempt an open frame.
// Ports    : clk                   - system clock (rising edge)
//            rst_n                 - synchronous active-low reset
//            channel_init_finished - lane/channel init complete (level)
//            axi_valid, axi_last   - AXI-Stream TX handshake inputs
//            axi_ready             - AXI-Stream TX ready (from registers)
//            block_sel             - 0=IDLE 1=DATA 2=CC (3 never driven)
//            data_last             - qualifies DATA as last word of frame
//            frame_active          - frame started, last word not yet sent
//            cc_active             - scheduler is in a CC burst
//            sched_ready           - scheduler is in RUN or CC
// Revision : 1.0 - initial release
// ============================================================================
module tx_block_scheduler #(
  parameter int CC_PERIOD    = 10000,
  parameter int CC_LENGTH    = 3,
  parameter int WARMUP_IDLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       channel_init_finished,
  input  logic       axi_valid,
  input  logic       axi_last,
  output logic       axi_ready,
  output logic [1:0] block_sel,
  output logic       data_last,
  output logic       frame_active,
  output logic       cc_active,
  output logic       sched_ready
);

  localparam int CNT_W   = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
  localparam int LEN_MAX = (CC_LENGTH > WARMUP_IDLES) ? CC_LENGTH : WARMUP_IDLES;
  localparam int LEN_W   = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;

  localparam logic [CNT_W-1:0] CC_CNT_LAST = CNT_W'(CC_PERIOD - 1);
  localparam logic [LEN_W-1:0] WARM_LAST   = LEN_W'(WARMUP_IDLES - 1);
  localparam logic [LEN_W-1:0] CC_LEN_LAST = LEN_W'(CC_LENGTH - 1);

  localparam logic [1:0] SEL_IDLE = 2'd0;
  localparam logic [1:0] SEL_DATA = 2'd1;
  localparam logic [1:0] SEL_CC   = 2'd2;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_CC     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cc_cnt_q, cc_cnt_d;
  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
  logic [1:0]       block_sel_q, block_sel_d;
  logic             data_last_q, data_last_d;
  logic             frame_active_q, frame_active_d;
  logic             cc_active_q, cc_active_d;
  logic             sched_ready_q, sched_ready_d;

  logic             xfer;
  logic [CNT_W-1:0] cc_cnt_inc;

  // Ready is withheld on the cycle before a CC burst so that no accepted
  // word can collide with CC entry.
  assign axi_ready = (state_q == ST_RUN) && (cc_cnt_q != CC_CNT_LAST) &&
                     channel_init_finished;
  assign xfer       = axi_valid && axi_ready;
  assign cc_cnt_inc = (cc_cnt_q == CC_CNT_LAST) ? '0 : cc_cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cc_cnt_d  = cc_cnt_q;
    len_cnt_d = len_cnt_q;

    case (state_q)
      ST_INIT: begin
        cc_cnt_d  = '0;
        len_cnt_d = '0;
        if (channel_init_finished) begin
          state_d = ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        cc_cnt_d = cc_cnt_inc;
        if (len_cnt_q == WARM_LAST) begin
          state_d   = ST_RUN;
          len_cnt_d = '0;
        end else begin
          len_cnt_d = len_cnt_q + LEN_W'(1);
        end
      end
      ST_RUN: begin
        cc_cnt_d  = cc_cnt_inc;
        len_cnt_d = '0;
        if (cc_cnt_q == CC_CNT_LAST) begin
          state_d = ST_CC;
        end
      end
      ST_CC: begin
        cc_cnt_d = cc_cnt_inc;
        if (len_cnt_q == CC_LEN_LAST) begin
          state_d   = ST_RUN;
          len_cnt_d = '0;
        end else begin
          len_cnt_d = len_cnt_q + LEN_W'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Losing the channel overrides everything and restarts from INIT.
    if (!channel_init_finished) begin
      state_d   = ST_INIT;
      cc_cnt_d  = '0;
      len_cnt_d = '0;
    end

    // Output registers decode the next state so they line up with block_sel.
    if (state_d == ST_CC) begin
      block_sel_d = SEL_CC;
    end else if (xfer) begin
      block_sel_d = SEL_DATA;
    end else begin
      block_sel_d = SEL_IDLE;
    end
    data_last_d   = xfer && axi_last;
    cc_active_d   = (state_d == ST_CC);
    sched_ready_d = (state_d == ST_RUN) || (state_d == ST_CC);

    // An open frame survives CC; only a channel drop aborts it.
    frame_active_d = frame_active_q;
    if (xfer) begin
      frame_active_d = !axi_last;
    end
    if (!channel_init_finished) begin
      frame_active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_INIT;
      cc_cnt_q       <= '0;
      len_cnt_q      <= '0;
      block_sel_q    <= SEL_IDLE;
      data_last_q    <= 1'b0;
      frame_active_q <= 1'b0;
      cc_active_q    <= 1'b0;
      sched_ready_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cc_cnt_q       <= cc_cnt_d;
      len_cnt_q      <= len_cnt_d;
      block_sel_q    <= block_sel_d;
      data_last_q    <= data_last_d;
      frame_active_q <= frame_active_d;
      cc_active_q    <= cc_active_d;
      sched_ready_q  <= sched_ready_d;
    end
  end

  assign block_sel    = block_sel_q;
  assign data_last    = data_last_q;
  assign frame_active = frame_active_q;
  assign cc_active    = cc_active_q;
  assign sched_ready  = sched_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_block_scheduler
// Purpose  : Self-checking bench for tx_block_scheduler. A reference model
//            tracks "cycles since leaving INIT" and derives the phase
//            (warm-up / run / CC) arithmetically from it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_block_scheduler;

  localparam int P = 16;
  localparam int L = 3;
  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cif = 1'b0;
  logic       axi_valid = 1'b0;
  logic       axi_last = 1'b0;
  logic       axi_ready;
  logic [1:0] block_sel;
  logic       data_last;
  logic       frame_active;
  logic       cc_active;
  logic       sched_ready;

  tx_block_scheduler #(
    .CC_PERIOD   (P),
    .CC_LENGTH   (L),
    .WARMUP_IDLES(W)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .channel_init_finished(cif),
    .axi_valid            (axi_valid),
    .axi_last             (axi_last),
    .axi_ready            (axi_ready),
    .block_sel            (block_sel),
    .data_last            (data_last),
    .frame_active         (frame_active),
    .cc_active            (cc_active),
    .sched_ready          (sched_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         m_active = 1'b0;
  int         m_t = 0;
  bit         m_frame = 1'b0;
  logic       m_xfer = 1'b0;
  logic       exp_ready = 1'b0;
  logic       act_ready = 1'b0;
  logic [1:0] exp_sel = 2'd0;
  logic       exp_last = 1'b0;
  logic       exp_frame = 1'b0;
  logic       exp_cc = 1'b0;
  logic       exp_sr = 1'b0;

  function automatic bit is_cc(input int t);
    return (t >= P) && ((t % P) < L);
  endfunction

  function automatic bit is_warm(input int t);
    return t < W;
  endfunction

  function automatic bit model_ready();
    return m_active && cif && !is_warm(m_t) && !is_cc(m_t) && ((m_t % P) != P - 1);
  endfunction

  function automatic logic [6:0] obs_vec();
    return {block_sel, data_last, frame_active, cc_active, sched_ready, act_ready};
  endfunction

  function automatic logic [6:0] exp_vec();
    return {exp_sel, exp_last, exp_frame, exp_cc, exp_sr, exp_ready};
  endfunction

  // One clock cycle: drive inputs, sample comb ready mid-cycle, advance model.
  // Entered and left at posedge+1.
  task automatic cycle(input logic v, input logic l);
    axi_valid = v;
    axi_last  = l;
    #3;
    act_ready = axi_ready;
    exp_ready = model_ready();
    m_xfer    = v && exp_ready;
    @(posedge clk);
    #1;
    if (!rst_n || !cif) begin
      m_active  = 1'b0;
      m_t       = 0;
      m_frame   = 1'b0;
      exp_sel   = 2'd0;
      exp_last  = 1'b0;
      exp_frame = 1'b0;
      exp_cc    = 1'b0;
      exp_sr    = 1'b0;
    end else begin
      if (!m_active) begin
        m_active = 1'b1;
        m_t      = 0;
      end else begin
        m_t++;
      end
      exp_cc    = is_cc(m_t);
      exp_sr    = !is_warm(m_t);
      exp_sel   = exp_cc ? 2'd2 : (m_xfer ? 2'd1 : 2'd0);
      exp_last  = m_xfer && l;
      if (m_xfer) m_frame = !l;
      exp_frame = m_frame;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cif = i[0];
      cycle(1'($urandom % 2), 1'($urandom % 2));
      checks++;
      if (obs_vec() !== 7'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b required=%b", i, obs_vec(), 7'b0);
      end
    end
    rst_n = 1'b1;
    cif   = 1'b0;
    cycle(1'b1, 1'b1);
    checks++;
    if (obs_vec() !== 7'b0) begin
      errors++;
      $display("FAIL reset_init got=%b required=%b", obs_vec(), 7'b0);
    end
  endtask

  task automatic test_warmup();
    int  zeros = 0;
    bit  seen  = 1'b0;
    cif = 1'b1;
    cycle(1'b1, 1'b0);
    checks++;
    if (act_ready !== 1'b0) begin
      errors++;
      $display("FAIL warmup_init_ready got=%b required=0", act_ready);
    end
    for (int i = 0; i < 12 && !seen; i++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL warmup_cycle got=%b required=%b", obs_vec(), exp_vec());
      end
      if (act_ready === 1'b1) seen = 1'b1;
      else zeros++;
    end
    checks++;
    if (!seen || zeros != W) begin
      errors++;
      $display("FAIL warmup_len seen=%0d got=%0d required=%0d", seen, zeros, W);
    end
    checks++;
    if (sched_ready !== 1'b1) begin
      errors++;
      $display("FAIL warmup_sched_ready got=%b required=1", sched_ready);
    end
  endtask

  task automatic test_frame5();
    int sent = 0, data_cnt = 0, last_cnt = 0;
    for (int i = 0; i < 40 && sent < 5; i++) begin
      cycle(1'b1, sent == 4);
      if (m_xfer) sent++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL frame5_cycle got=%b required=%b", obs_vec(), exp_vec());
      end
      if (block_sel === 2'd1) data_cnt++;
      if (data_last === 1'b1) last_cnt++;
    end
    checks++;
    if (data_cnt != 5 || last_cnt != 1 || frame_active !== 1'b0) begin
      errors++;
      $display("FAIL frame5_totals got data=%0d last=%0d fa=%b required data=5 last=1 fa=0",
               data_cnt, last_cnt, frame_active);
    end
  endtask

  task automatic test_cc_period();
    int  cc_cycles = 0, blen = 0, lowrun = 0, last_start = -1;
    bit  in_burst = 1'b0, burst_seen_start = 1'b0, seen_high = 1'b0;
    for (int i = 0; i < 48; i++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL cc_cycle got=%b required=%b", obs_vec(), exp_vec());
      end
      if (act_ready === 1'b1) begin
        if (seen_high && lowrun > 0) begin
          checks++;
          if (lowrun != L + 1) begin
            errors++;
            $display("FAIL cc_ready_low got=%0d required=%0d", lowrun, L + 1);
          end
        end
        seen_high = 1'b1;
        lowrun    = 0;
      end else begin
        lowrun++;
      end
      if (cc_active === 1'b1 && block_sel === 2'd2) begin
        cc_cycles++;
        if (!in_burst) begin
          if (last_start >= 0) begin
            checks++;
            if (i - last_start != P) begin
              errors++;
              $display("FAIL cc_spacing got=%0d required=%0d", i - last_start, P);
            end
          end
          last_start       = i;
          burst_seen_start = 1'b1;
          blen             = 0;
        end
        in_burst = 1'b1;
        blen++;
      end else begin
        if (in_burst && burst_seen_start) begin
          checks++;
          if (blen != L) begin
            errors++;
            $display("FAIL cc_burst_len got=%0d required=%0d", blen, L);
          end
        end
        in_burst = 1'b0;
      end
    end
    checks++;
    if (cc_cycles != 3 * L) begin
      errors++;
      $display("FAIL cc_count got=%0d required=%0d", cc_cycles, 3 * L);
    end
  endtask

  task automatic test_cc_split();
    int sent = 0, data_cnt = 0, cc_in_frame = 0;
    for (int i = 0; i < 40 && !((m_t % P) == 10 && model_ready()); i++) cycle(1'b0, 1'b0);
    checks++;
    if (!((m_t % P) == 10 && model_ready())) begin
      errors++;
      $display("FAIL split_align got t=%0d required phase=10", m_t);
    end
    for (int i = 0; i < 60 && sent < 12; i++) begin
      cycle(1'b1, sent == 11);
      if (m_xfer) sent++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL split_cycle got=%b required=%b", obs_vec(), exp_vec());
      end
      if (block_sel === 2'd1) data_cnt++;
      if (cc_active === 1'b1) begin
        cc_in_frame++;
        checks++;
        if (frame_active !== 1'b1) begin
          errors++;
          $display("FAIL split_frame_in_cc got=%b required=1", frame_active);
        end
      end
    end
    checks++;
    if (data_cnt != 12 || cc_in_frame != L) begin
      errors++;
      $display("FAIL split_totals got data=%0d cc=%0d required data=12 cc=%0d",
               data_cnt, cc_in_frame, L);
    end
  endtask

  task automatic test_drop(input bit mid_cc);
    int  zeros = 0, cc_at = 0;
    bit  seen_high = 1'b0, reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      if (mid_cc) begin
        cycle(1'b0, 1'b0);
        reached = (cc_active === 1'b1) && ((m_t % P) == 1);
      end else begin
        cycle(1'b1, 1'b0);
        reached = (frame_active === 1'b1) && model_ready();
      end
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL drop_setup mid_cc=%0d got=0 required=1", mid_cc);
    end
    cif = 1'b0;
    cycle(1'b1, 1'b0);
    checks++;
    if (obs_vec() !== 7'b0) begin
      errors++;
      $display("FAIL drop_outputs mid_cc=%0d got=%b required=%b", mid_cc, obs_vec(), 7'b0);
    end
    cif = 1'b1;
    cycle(1'b0, 1'b0);
    for (int n = 1; n <= 40 && cc_at == 0; n++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL drop_rerun_cycle got=%b required=%b", obs_vec(), exp_vec());
      end
      if (act_ready === 1'b1) seen_high = 1'b1;
      else if (!seen_high) zeros++;
      if (cc_active === 1'b1) cc_at = n;
    end
    checks++;
    if (zeros != W || cc_at != P) begin
      errors++;
      $display("FAIL drop_rewarm mid_cc=%0d got warm=%0d cc_at=%0d required warm=%0d cc_at=%0d",
               mid_cc, zeros, cc_at, W, P);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      cif = ($urandom % 400) != 0;
      cycle(1'(($urandom % 4) != 0), 1'(($urandom % 5) == 0));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle i=%0d got=%b required=%b", i, obs_vec(), exp_vec());
      end
      checks++;
      if (block_sel === 2'd3) begin
        errors++;
        $display("FAIL random_sel_reserved i=%0d got=3 required!=3", i);
      end
    end
    cif = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_warmup();
    test_frame5();
    test_cc_period();
    test_cc_split();
    test_drop(1'b0);
    test_drop(1'b1);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_block_scheduler.md
Name: tx_block_scheduler

Overview:
- Per-cycle TX sequencer in front of data_controller.
- Each cycle it decides whether the lanes carry idle blocks, clock-compensation (CC) ordered sets or AXI user data.
- Drives AXI backpressure (axi_ready) and the block-type select that data_controller uses to mux ordered_sets_encoder output against AXI data.
- Enforces the post-init warm-up idles and periodic CC insertion.

Parameters:
- CC_PERIOD, 10000, cycles between starts of consecutive CC bursts; must be > CC_LENGTH and > WARMUP_IDLES.
- CC_LENGTH, 3, consecutive CC blocks per burst; must be ≥ 1.
- WARMUP_IDLES, 4, idle cycles sent after channel_init_finished rises, before data is accepted; must be ≥ 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- channel_init_finished  in  1  lane/channel init complete; level-sensitive.
- axi_valid  in  1  AXI-Stream TX valid.
- axi_last  in  1  AXI-Stream TX last; sampled on transfer.
- axi_ready  out  1  AXI-Stream TX ready.
- block_sel  out  2  block type this cycle: 0=IDLE, 1=DATA, 2=CC, 3=reserved (never driven).
- data_last  out  1  qualifies block_sel==DATA as the final word of a frame.
- frame_active  out  1  a frame has started but its last word has not been transferred.
- cc_active  out  1  FSM is in CC.
- sched_ready  out  1  FSM is in RUN or CC.

Behaviour:
- Clocking and reset: single clock; reset synchronous, active-low.
- Reset values: state=INIT; cc_cnt=0; len_cnt=0; all outputs 0 (block_sel=IDLE).
- States:
  - INIT: wait for channel_init_finished=1, then go to WARMUP with len_cnt=0.
  - WARMUP: len_cnt increments each cycle; at len_cnt==WARMUP_IDLES-1, go to RUN.
  - RUN: accept data. When cc_cnt==CC_PERIOD-1, go to CC with len_cnt=0.
  - CC: len_cnt increments each cycle; at len_cnt==CC_LENGTH-1, go back to RUN.
- cc_cnt:
  - Held at 0 in INIT.
  - Increments every cycle in WARMUP, RUN and CC; wraps CC_PERIOD-1→0.
  - Width $clog2(CC_PERIOD).
  - First CC burst begins CC_PERIOD cycles after leaving INIT.
- axi_ready: combinational from registers = (state==RUN) && (cc_cnt!=CC_PERIOD-1) && channel_init_finished.
  - Low for the whole CC burst and for the cycle before it.
  - No transfer can coincide with CC entry.
- Transfer: axi_valid && axi_ready at a rising edge.
- block_sel (registered; one cycle of latency from transfer to block_sel==DATA):
  - Next value CC if next state is CC.
  - Otherwise DATA on a transfer.
  - Otherwise IDLE.
- data_last: registered; set to axi_last on a transfer, 0 otherwise.
- frame_active: set on a transfer with axi_last=0; cleared on a transfer with axi_last=1. A transfer with axi_valid and axi_last both 1 while idle leaves it 0.
- CC preemption:
  - CC may interrupt an open frame; frame_active stays 1 through CC.
  - The frame resumes in RUN with no loss or duplication.
- cc_active / sched_ready: registered decode of the next state (aligned with block_sel).
- channel_init_finished falling in any non-INIT state:
  - Next edge forces INIT; cc_cnt=0, len_cnt=0.
  - All outputs return to reset values, including frame_active=0 (frame aborted).
  - axi_ready drops combinationally in the same cycle.
- Input handling: axi_valid while axi_ready=0 is ignored. AXI-side stability of data while stalled is the master's duty.

Test Plan (CC_PERIOD=16, CC_LENGTH=3, WARMUP_IDLES=4):
1. Reset held 3 cycles with inputs toggling → all outputs 0, block_sel=0, state INIT. Raise channel_init_finished → exactly 4 cycles axi_ready=0, then axi_ready=1, sched_ready=1.
2. Continuous axi_valid=1, 5-word frame (last on word 5) → five block_sel=1 cycles each one cycle after its transfer; data_last=1 only on the 5th; frame_active 1 from word 1 until the word-5 edge.
3. Free-running → CC bursts: block_sel=2, cc_active=1 for exactly 3 cycles every 16 cycles. axi_ready=0 for 4 cycles (pre-cycle + 3).
4. Frame of 12 words with axi_valid held → CC splits it; frame_active stays 1 across CC; all 12 words appear as DATA with none lost or duplicated.
5. Drop channel_init_finished mid-frame and mid-CC (separate runs) → next cycle all outputs 0, frame_active=0. Re-raise → 4-cycle warm-up again, first CC 16 cycles after exit from INIT.
6. Random axi_valid/axi_last over 2000 cycles vs. reference model → block_sel, data_last and frame_active match; block_sel never 3.
